// File: rtl/avmm_copy_master.sv
// avmm_copy_master: Avalon-MM initiator copying word_count words from src_addr to dst_addr on a RAM slave.
// Ports: clk, reset (sync, active-high); start/src_addr/dst_addr/word_count program a copy;
//   busy/done report progress; m_* is the Avalon-MM master port toward the RAM slave.
// Define AVMM_COPY_VERIFY_EN to read back every written word and add sticky error/err_addr outputs.
module avmm_copy_master #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [ADDR_W:0]     word_count,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    input  logic [DATA_W-1:0]   m_readdata,
    input  logic                m_waitrequest
`ifdef AVMM_COPY_VERIFY_EN
    ,
    output logic                error,
    output logic [ADDR_W-1:0]   err_addr
`endif
);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, VREAD, VWAIT} state_t;
    localparam logic [ADDR_W:0] ONE = 1;
    localparam logic [2:0] LAT = 3'(READ_LATENCY);
    state_t state, state_nx;
    logic [ADDR_W-1:0] src, dst;
    logic [ADDR_W:0] cnt, idx;
    logic [2:0] lat;
    logic [DATA_W-1:0] held;
    logic last, step;
    assign last = (idx + ONE) == cnt;
    // The index advances only once a word is fully handled, so readback still addresses dst+idx.
`ifdef AVMM_COPY_VERIFY_EN
    assign step = state == VWAIT && lat == 3'd1;
`else
    assign step = state == WRITE && !m_waitrequest;
`endif
    always_comb begin
        state_nx = state;
        busy = 1'b0;
        done = 1'b0;
        m_chipselect = 1'b0;
        m_write = 1'b0;
        m_address = '0;
        m_writedata = '0;
        case (state)
            IDLE: if (start) state_nx = (word_count == '0) ? DONE : READ;
            READ: begin
                busy = 1'b1;
                m_chipselect = 1'b1;
                m_address = src + idx[ADDR_W-1:0];
                if (!m_waitrequest) state_nx = WAIT;
            end
            WAIT: begin
                busy = 1'b1;
                if (lat == 3'd1) state_nx = WRITE;
            end
            WRITE: begin
                busy = 1'b1;
                m_chipselect = 1'b1;
                m_write = 1'b1;
                m_address = dst + idx[ADDR_W-1:0];
                m_writedata = held;
`ifdef AVMM_COPY_VERIFY_EN
                if (!m_waitrequest) state_nx = VREAD;
`else
                if (!m_waitrequest) state_nx = last ? DONE : READ;
`endif
            end
`ifdef AVMM_COPY_VERIFY_EN
            VREAD: begin
                busy = 1'b1;
                m_chipselect = 1'b1;
                m_address = dst + idx[ADDR_W-1:0];
                if (!m_waitrequest) state_nx = VWAIT;
            end
            VWAIT: begin
                busy = 1'b1;
                if (lat == 3'd1) state_nx = last ? DONE : READ;
            end
`endif
            DONE: begin
                done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        m_byteenable = m_chipselect ? '1 : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            cnt <= '0;
            idx <= '0;
            lat <= '0;
            held <= '0;
`ifdef AVMM_COPY_VERIFY_EN
            error <= 1'b0;
            err_addr <= '0;
`endif
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                src <= src_addr;
                dst <= dst_addr;
                cnt <= word_count;
                idx <= '0;
`ifdef AVMM_COPY_VERIFY_EN
                error <= 1'b0;
                err_addr <= '0;
`endif
            end
            if ((state == READ || state == VREAD) && !m_waitrequest) lat <= LAT;
            if (state == WAIT || state == VWAIT) lat <= lat - 3'd1;
            if (state == WAIT && lat == 3'd1) held <= m_readdata;
            if (step) idx <= idx + ONE;
`ifdef AVMM_COPY_VERIFY_EN
            if (state == VWAIT && lat == 3'd1 && m_readdata != held && !error) begin
                error <= 1'b1;
                err_addr <= dst + idx[ADDR_W-1:0];
            end
`endif
        end
    end
endmodule

// File: tb/tb_avmm_copy_master.sv
// tb_avmm_copy_master: directed self-checking bench for avmm_copy_master against a latency-1 RAM model.
module tb_avmm_copy_master;
`ifdef AVMM_COPY_VERIFY_EN
    localparam int PW = 5;
    localparam int CSW = 3;
    localparam int RS = 2;
`else
    localparam int PW = 3;
    localparam int CSW = 2;
    localparam int RS = 1;
`endif
    logic clk, reset, start, busy, done, m_chipselect, m_write, waitrequest;
    logic [9:0] src_addr, dst_addr, m_address;
    logic [10:0] word_count;
    logic [3:0] m_byteenable;
    logic [31:0] m_writedata, rdata;
`ifdef AVMM_COPY_VERIFY_EN
    logic error;
    logic [9:0] err_addr;
`endif
    logic [31:0] mem [1024];
    logic [9:0] rd_log [64];
    logic [9:0] wr_log [64];
    logic [5:0] rd_n, wr_n;
    logic clr_log, pl_en, corrupt;
    logic [9:0] pl_addr;
    logic [31:0] pl_data;
    int total, bad;

    avmm_copy_master dut (
        .clk(clk), .reset(reset), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
        .word_count(word_count), .busy(busy), .done(done), .m_address(m_address),
        .m_byteenable(m_byteenable), .m_chipselect(m_chipselect), .m_write(m_write),
        .m_writedata(m_writedata), .m_readdata(rdata), .m_waitrequest(waitrequest)
`ifdef AVMM_COPY_VERIFY_EN
        , .error(error), .err_addr(err_addr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr_log) begin
            rd_n <= '0;
            wr_n <= '0;
        end
        if (pl_en) mem[pl_addr] <= pl_data;
        if (m_chipselect && !waitrequest) begin
            if (m_write) begin
                mem[m_address] <= (corrupt && m_address == 10'h101) ? m_writedata ^ 32'h1 : m_writedata;
                wr_log[wr_n] <= m_address;
                wr_n <= wr_n + 6'd1;
            end else begin
                rdata <= mem[m_address];
                rd_log[rd_n] <= m_address;
                rd_n <= rd_n + 6'd1;
            end
        end
    end

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_en = 1'b1;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic clear_log();
        @(negedge clk);
        clr_log = 1'b1;
        @(negedge clk);
        clr_log = 1'b0;
    endtask

    task automatic run_copy(input logic [9:0] s, input logic [9:0] d, input logic [10:0] n,
                            input int rs, input int ws, output int done_at, output int done_cnt,
                            output int busy_cnt, output int cs_cnt);
        logic st, pw;
        logic [9:0] pa;
        logic [31:0] pd;
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        word_count = n;
        start = 1'b1;
        waitrequest = 1'b0;
        done_at = -1;
        done_cnt = 0;
        busy_cnt = 0;
        cs_cnt = 0;
        st = 1'b0;
        pw = 1'b0;
        pa = '0;
        pd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == 2 && n > 11'd1) || (k == 1 && n == 11'd0);
            src_addr = 10'h2AA;
            dst_addr = 10'h155;
            word_count = 11'd7;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            busy_cnt += int'(busy);
            cs_cnt += int'(m_chipselect);
            total++;
            if (m_byteenable !== (m_chipselect ? 4'hF : 4'h0)) begin
                bad++;
                $display("FAIL byteenable cycle %0d: got %h cs=%b", k, m_byteenable, m_chipselect);
            end
            if (st) begin
                total++;
                if ({m_chipselect, m_write, m_address, m_writedata} !== {1'b1, pw, pa, pd}) begin
                    bad++;
                    $display("FAIL stall_hold cycle %0d: got cs=%b wr=%b a=%h d=%h want wr=%b a=%h d=%h",
                             k, m_chipselect, m_write, m_address, m_writedata, pw, pa, pd);
                end
            end
            st = 1'b0;
            if (m_chipselect && !m_write && rs > 0) begin
                st = 1'b1;
                rs--;
            end else if (m_chipselect && m_write && ws > 0) begin
                st = 1'b1;
                ws--;
            end
            waitrequest = st;
            pa = m_address;
            pw = m_write;
            pd = m_writedata;
        end
        start = 1'b0;
        waitrequest = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, m_chipselect, m_write, m_byteenable, m_address, m_writedata} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b done=%b cs=%b wr=%b be=%h a=%h d=%h required all 0",
                     busy, done, m_chipselect, m_write, m_byteenable, m_address, m_writedata);
        end
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, m_chipselect} !== 3'b000) begin
            bad++;
            $display("FAIL idle_after_reset: got busy=%b done=%b cs=%b required 000", busy, done, m_chipselect);
        end
    endtask

    task automatic test_basic();
        int da, dc, bc, cc;
        for (int i = 0; i < 4; i++) poke(10'h010 + 10'(i), 32'hA0 + 32'(i));
        run_copy(10'h010, 10'h100, 11'd4, 0, 0, da, dc, bc, cc);
        total += 4;
        if (da !== 4 * PW + 1) begin bad++; $display("FAIL basic_done_at: got %0d required %0d", da, 4 * PW + 1); end
        if (dc !== 1) begin bad++; $display("FAIL basic_done_count: got %0d required 1", dc); end
        if (bc !== 4 * PW) begin bad++; $display("FAIL basic_busy: got %0d required %0d", bc, 4 * PW); end
        if (cc !== 4 * CSW) begin bad++; $display("FAIL basic_cs: got %0d required %0d", cc, 4 * CSW); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[10'h100 + 10'(i)] !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL basic_data[%0d]: got %h required %h", i, mem[10'h100 + 10'(i)], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_zero();
        int da, dc, bc, cc;
        run_copy(10'h020, 10'h030, 11'd0, 0, 0, da, dc, bc, cc);
        total += 4;
        if (da !== 1) begin bad++; $display("FAIL zero_done_at: got %0d required 1", da); end
        if (dc !== 1) begin bad++; $display("FAIL zero_done_count: got %0d required 1", dc); end
        if (bc !== 0) begin bad++; $display("FAIL zero_busy: got %0d required 0", bc); end
        if (cc !== 0) begin bad++; $display("FAIL zero_cs: got %0d required 0", cc); end
    endtask

    task automatic test_wrap();
        int da, dc, bc, cc;
        poke(10'h3FF, 32'h1111_1111);
        poke(10'h000, 32'h2222_2222);
        clear_log();
        run_copy(10'h3FF, 10'h1FF, 11'd2, 0, 0, da, dc, bc, cc);
        total += 7;
        if (rd_log[0] !== 10'h3FF) begin bad++; $display("FAIL wrap_rd0: got %h required 3ff", rd_log[0]); end
        if (rd_log[RS] !== 10'h000) begin bad++; $display("FAIL wrap_rd1: got %h required 000", rd_log[RS]); end
        if (wr_log[0] !== 10'h1FF) begin bad++; $display("FAIL wrap_wr0: got %h required 1ff", wr_log[0]); end
        if (wr_log[1] !== 10'h200) begin bad++; $display("FAIL wrap_wr1: got %h required 200", wr_log[1]); end
        if (mem[10'h1FF] !== 32'h1111_1111) begin bad++; $display("FAIL wrap_d0: got %h required 11111111", mem[10'h1FF]); end
        if (mem[10'h200] !== 32'h2222_2222) begin bad++; $display("FAIL wrap_d1: got %h required 22222222", mem[10'h200]); end
        if (da !== 2 * PW + 1) begin bad++; $display("FAIL wrap_done_at: got %0d required %0d", da, 2 * PW + 1); end
    endtask

    task automatic test_stall();
        int da, dc, bc, cc;
        run_copy(10'h010, 10'h180, 11'd4, 3, 2, da, dc, bc, cc);
        total += 2;
        if (da !== 4 * PW + 6) begin bad++; $display("FAIL stall_done_at: got %0d required %0d", da, 4 * PW + 6); end
        if (dc !== 1) begin bad++; $display("FAIL stall_done_count: got %0d required 1", dc); end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[10'h180 + 10'(i)] !== 32'hA0 + 32'(i)) begin
                bad++;
                $display("FAIL stall_data[%0d]: got %h required %h", i, mem[10'h180 + 10'(i)], 32'hA0 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_mid();
        int da, dc, bc, cc, dn;
        for (int i = 0; i < 4; i++) poke(10'h140 + 10'(i), 32'hDEAD_0000 + 32'(i));
        @(negedge clk);
        src_addr = 10'h010;
        dst_addr = 10'h140;
        word_count = 11'd4;
        start = 1'b1;
        for (int k = 1; k <= PW + 2; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        total++;
        if ({busy, m_chipselect} !== 2'b10) begin
            bad++;
            $display("FAIL mid_in_wait: got busy=%b cs=%b required 10", busy, m_chipselect);
        end
        reset = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, m_chipselect, m_write, m_byteenable, m_address, m_writedata} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got busy=%b done=%b cs=%b wr=%b be=%h a=%h d=%h required all 0",
                     busy, done, m_chipselect, m_write, m_byteenable, m_address, m_writedata);
        end
        reset = 1'b0;
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            dn += int'(done) + int'(m_chipselect);
        end
        total += 3;
        if (dn !== 0) begin bad++; $display("FAIL mid_quiet: got %0d done/cs cycles required 0", dn); end
        if (mem[10'h140] !== 32'hA0) begin bad++; $display("FAIL mid_word0: got %h required a0", mem[10'h140]); end
        if (mem[10'h141] !== 32'hDEAD_0001) begin bad++; $display("FAIL mid_word1: got %h required dead0001", mem[10'h141]); end
        run_copy(10'h010, 10'h140, 11'd2, 0, 0, da, dc, bc, cc);
        total += 2;
        if (da !== 2 * PW + 1) begin bad++; $display("FAIL mid_restart_done_at: got %0d required %0d", da, 2 * PW + 1); end
        if (mem[10'h141] !== 32'hA1) begin bad++; $display("FAIL mid_restart_data: got %h required a1", mem[10'h141]); end
    endtask

`ifdef AVMM_COPY_VERIFY_EN
    task automatic test_verify();
        int da, dc, bc, cc;
        corrupt = 1'b1;
        run_copy(10'h010, 10'h100, 11'd4, 0, 0, da, dc, bc, cc);
        corrupt = 1'b0;
        total += 4;
        if (error !== 1'b1) begin bad++; $display("FAIL verify_error: got %b required 1", error); end
        if (err_addr !== 10'h101) begin bad++; $display("FAIL verify_err_addr: got %h required 101", err_addr); end
        if (dc !== 1) begin bad++; $display("FAIL verify_done_count: got %0d required 1", dc); end
        if (da !== 4 * PW + 1) begin bad++; $display("FAIL verify_done_at: got %0d required %0d", da, 4 * PW + 1); end
        @(negedge clk);
        src_addr = 10'h010;
        dst_addr = 10'h104;
        word_count = 11'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (error !== 1'b0) begin bad++; $display("FAIL verify_clear: got %b required 0", error); end
        repeat (PW + 2) @(negedge clk);
    endtask
`endif

    initial begin
        total = 0;
        bad = 0;
        start = 1'b0;
        waitrequest = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        word_count = '0;
        clr_log = 1'b0;
        pl_en = 1'b0;
        pl_addr = '0;
        pl_data = '0;
        corrupt = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_stall();
        test_reset_mid();
`ifdef AVMM_COPY_VERIFY_EN
        test_verify();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/avmm_copy_master.md
Name: avmm_copy_master

Overview:
- Avalon-MM initiator (master) that drives the on-chip RAM slave port (address/byteenable/chipselect/write/writedata/readdata).
- Copies a block of 32-bit words from a source word address to a destination word address, one word at a time.
- Used for RAM initialisation, buffer moves and self-test.
- Sits beside the CPU on the RAM slave port; the CPU programs it via start/parameter inputs.

Parameters:
- ADDR_W, 10, word-address width; must match the slave address width.
- DATA_W, 32, data width; byteenable width is DATA_W/8.
- READ_LATENCY, 1, fixed cycles from read acceptance to valid readdata; legal range 1..4.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- src_addr  in  ADDR_W  first source word address; captured on accepted start.
- dst_addr  in  ADDR_W  first destination word address; captured on accepted start.
- word_count  in  ADDR_W+1  number of words to copy, 0..2^ADDR_W; captured on accepted start.
- busy  out  1  high from the cycle after start acceptance until done.
- done  out  1  one-cycle pulse at completion.
- m_address  out  ADDR_W  master word address.
- m_byteenable  out  DATA_W/8  always all-ones while chipselect is high, else 0.
- m_chipselect  out  1  transfer request.
- m_write  out  1  1 = write, 0 = read; valid only with chipselect.
- m_writedata  out  DATA_W  write data.
- m_readdata  in  DATA_W  read data.
- m_waitrequest  in  1  slave stall; tie to 0 for the on-chip RAM.

Behaviour:
- Reset (synchronous, any state): state=IDLE; busy, done, m_chipselect, m_write, m_byteenable, m_address, m_writedata all 0; internal index and captured parameters cleared.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE → READ when start=1 and word_count≠0. Captures src/dst/count and sets index=0.
- IDLE → DONE when start=1 and word_count=0. No bus transfer occurs.
- READ:
  - chipselect=1, write=0, address=src+index (mod 2^ADDR_W).
  - Held stable while waitrequest=1.
  - Read is accepted on the edge where waitrequest=0; then → WAIT with the latency counter loaded to READ_LATENCY.
- WAIT:
  - chipselect=0.
  - Counter decrements each cycle.
  - In the last WAIT cycle, readdata is registered into the data holding register; → WRITE.
- WRITE:
  - chipselect=1, write=1, address=dst+index (mod 2^ADDR_W), writedata=held word.
  - Held stable while waitrequest=1.
  - On acceptance, index increments. If index+1 == count → DONE, else → READ.
- DONE: done=1 for exactly one cycle, busy=0; → IDLE.
- busy=1 in READ, WAIT and WRITE only.
- Timing with no stalls: 2+READ_LATENCY cycles per word. With start sampled at edge 0, the first READ is in cycle 1. done is asserted N*(2+READ_LATENCY)+1 cycles after the start edge.
- start while not in IDLE (including the DONE cycle) is ignored. Input changes after capture have no effect.
- Address arithmetic wraps modulo 2^ADDR_W; e.g. src=0x3FF, count=2 reads 0x3FF then 0x000.
- Overlapping ranges: copies proceed in strictly ascending index order with no overlap protection. With dst=src+1, the source word is replicated.
- Reset mid-operation: the current transfer is abandoned on the reset edge, no done is pulsed, and chipselect drops in the next cycle.

Optional Feature:
- Macro: AVMM_COPY_VERIFY_EN.
- Enabled:
  - Adds output error (1 bit, sticky) and err_addr (ADDR_W).
  - After each accepted WRITE, states VREAD/VWAIT read back dst+index and compare with the held word.
  - On the first mismatch: error=1 and err_addr=that destination address.
  - The copy continues to completion. error and err_addr clear on reset or on the next accepted start.
  - Per-word cost becomes 3+2*READ_LATENCY cycles.
- Disabled: no readback states, no error/err_addr ports; timing exactly as in Behaviour.

Test Plan:
- Preload RAM[0x010..0x013]=0xA0..0xA3; start src=0x010, dst=0x100, count=4, L=1, waitrequest=0 → RAM[0x100..0x103]=0xA0..0xA3, done pulses exactly 13 cycles after the start edge, busy high 12 cycles.
- count=0 → no chipselect ever, done pulses in the cycle after start, busy stays 0.
- src=0x3FF, dst=0x1FF, count=2 → reads 0x3FF then 0x000, writes 0x1FF then 0x200.
- waitrequest held high 3 cycles on the first READ and 2 on the first WRITE → address, write and writedata stable while stalled; result correct; done delayed by exactly 5 cycles.
- Reset asserted in the WAIT state of word 2 of 4 → next cycle all outputs 0 and state IDLE, no done. Only word 0 is written. A subsequent start completes normally.
- With AVMM_COPY_VERIFY_EN, a bench model corrupts dst 0x101 (bit 0 flipped) → error=1, err_addr=0x101, done still pulses; the next start clears error.
